uart_tx_flow: RTL
=================

Name: uart_tx_flow

Overview:
UART transmitter with a 4-entry byte FIFO and CTS hardware flow control. It is the transmit counterpart of the system UART receiver and pairs with that block's RTS output. It serialises bytes onto TXD as start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It sits behind the APB UART register interface, which pushes bytes through a valid/ready port, and drives the TXD/TXD_EN pins of SYSTEM_TOP.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
DIV_W, 16, width of the baud divisor input.

Ports:
HCLK  input  1  system clock.
HRESETn  input  1  asynchronous active-low reset.
ENABLE  input  1  transmitter enable; gates only the start of a new frame.
DIV  input  DIV_W  bit period is DIV+1 HCLK cycles.
PARITY_EN  input  1  1 = insert parity bit after data.
PARITY_ODD  input  1  1 = odd parity, 0 = even parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
WDATA  input  8  byte to enqueue.
WVALID  input  1  write request.
WREADY  output  1  FIFO not full.
CTS  input  1  asynchronous; 1 = peer ready to receive.
TXD  output  1  serial data; idles high.
TXD_EN  output  1  high from first start-bit cycle through last stop-bit cycle.
BUSY  output  1  high while a frame is in progress.
TX_DONE  output  1  one-cycle pulse on the last cycle of the final stop bit.
FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: TXD=1, TXD_EN=0, BUSY=0, TX_DONE=0, FIFO_COUNT=0, WREADY=1, state IDLE, CTS synchroniser flops=0. Reset is asynchronous, so TXD returns to 1 immediately even mid-frame and the FIFO is flushed.
- CTS passes through a 2-flop synchroniser (cts_s). It is sampled only in IDLE; deassertion mid-frame never truncates a frame.
- FIFO push: happens when WVALID && WREADY at an edge. WREADY = (FIFO_COUNT != FIFO_DEPTH), combinational from the count. While full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, ordering preserved. Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: if ENABLE && cts_s && count!=0, pop the head byte into the shift register. In the same cycle, latch DIV, PARITY_EN, PARITY_ODD and STOP2, clear the bit counters, and go to START.
  - START: TXD=0 for DIV+1 cycles, then go to DATA.
  - DATA: TXD=shift[0]; shift right every DIV+1 cycles; after 8 bits go to PARITY if PARITY_EN, else to STOP.
  - PARITY: TXD = (XOR of the 8 data bits) XOR PARITY_ODD, for DIV+1 cycles, then go to STOP.
  - STOP: TXD=1 for (STOP2 ? 2 : 1)×(DIV+1) cycles. TX_DONE pulses on the last cycle. Next state is IDLE.
- TXD, TXD_EN and BUSY are registered. TXD_EN=BUSY=1 in START, DATA, PARITY and STOP.
- Latency: byte accepted into an empty FIFO at edge E with cts_s=1 and ENABLE=1 → pop at edge E+1 → TXD=0 visible after edge E+1.
- Back-to-back frames: if the FIFO is non-empty and cts_s=1 at the last STOP cycle, the next start bit begins on the cycle after the IDLE cycle. Exactly one idle-high cycle separates frames.
- Config changes (DIV, parity, STOP2) mid-frame have no effect until the next frame.
- ENABLE low mid-frame: the current frame completes, and no new pop occurs while ENABLE stays low.
- DIV=0: one HCLK cycle per bit, which must work.
- Bit-period counter: DIV_W bits; counts 0..DIV, then advances the bit.

Test Plan:
- Basic frame: DIV=3, PARITY_EN=0, STOP2=0, CTS=1, push 0xA5 → TXD = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles). TXD_EN is high for exactly those 40 cycles, and TX_DONE pulses once on cycle 40.
- Parity: DIV=1, PARITY_EN=1.
  - 0x07, even → parity bit 1.
  - 0x07, odd → parity bit 0.
  - STOP2=1 → stop high for 4 cycles; frame length 24 cycles.
- Flow control: CTS=0, push 0xFF, 0xAA, 0xBB, 0xCC → FIFO_COUNT=4, WREADY=0, TXD stays 1. Push of 0x00 while full is refused (count stays 4). Raise CTS → TXD falls 3 cycles later. Bytes are sent in order with a one-cycle idle gap between frames. Dropping CTS during byte 2's data bits still completes byte 2, and byte 3 does not start.
- Full with simultaneous pop: FIFO full, WVALID held high across the pop edge → push is refused on that edge and accepted on the following edge. Count goes 4→3→4.
- Reset mid-frame: assert HRESETn=0 during DATA of 0x3C with 2 bytes queued → TXD=1 and TXD_EN=0 asynchronously, count=0. After release, nothing is transmitted.
- DIV=0 with config change: DIV=0, push 0x55 → 10-cycle frame, alternating 0/1 from the start bit. Change DIV to 7 mid-frame → current frame unaffected; the next frame uses 8-cycle bits.

Source files
------------

// File: rtl/uart_tx_flow.sv
`default_nettype none
// ============================================================================
// uart_tx_flow : UART transmitter with byte FIFO and CTS flow control
// Revision     : 1.0
// ============================================================================
module uart_tx_flow #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          ENABLE,
    input  logic [DIV_W-1:0]              DIV,
    input  logic                          PARITY_EN,
    input  logic                          PARITY_ODD,
    input  logic                          STOP2,
    input  logic [7:0]                    WDATA,
    input  logic                          WVALID,
    output logic                          WREADY,
    input  logic                          CTS,
    output logic                          TXD,
    output logic                          TXD_EN,
    output logic                          BUSY,
    output logic                          TX_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             cts_meta, cts_s;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [7:0]       head;
    logic [DIV_W-1:0] div_l, baud, baud_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic             stop_cnt, stop_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             par_en_l, par_bit, stop2_l;
    logic             txd_nxt, busy_nxt, done_nxt, bit_end;

    assign WREADY     = (count != CW'(FIFO_DEPTH));
    assign push       = WVALID && WREADY;
    assign head       = mem[rd_ptr];
    assign FIFO_COUNT = count;
    assign bit_end    = (baud == div_l);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            cts_meta <= CTS;
            cts_s    <= cts_meta;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= WDATA;
    end

    // WREADY is derived from the pre-edge count, so a pop never frees a slot
    // for a push on the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud + DIV_W'(1);
        bit_nxt   = bit_cnt;
        stop_nxt  = stop_cnt;
        shift_nxt = shift;
        txd_nxt   = TXD;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                baud_nxt = '0;
                txd_nxt  = 1'b1;
                if (ENABLE && cts_s && (count != '0)) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
                    shift_nxt = head;
                    txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    txd_nxt   = shift[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt = par_en_l ? S_PARITY : S_STOP;
                        txd_nxt   = par_en_l ? par_bit : 1'b1;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        txd_nxt   = shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == stop2_l) begin
                        state_nxt = S_IDLE;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        // Registered TX_DONE: flag the cycle that will be the final stop cycle.
        done_nxt = (state_nxt == S_STOP) && (baud_nxt == div_l) && (stop_nxt == stop2_l);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            div_l    <= '0;
            par_en_l <= 1'b0;
            par_bit  <= 1'b0;
            stop2_l  <= 1'b0;
            TXD      <= 1'b1;
            TXD_EN   <= 1'b0;
            BUSY     <= 1'b0;
            TX_DONE  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud     <= baud_nxt;
            bit_cnt  <= bit_nxt;
            stop_cnt <= stop_nxt;
            shift    <= shift_nxt;
            TXD      <= txd_nxt;
            TXD_EN   <= busy_nxt;
            BUSY     <= busy_nxt;
            TX_DONE  <= done_nxt;
            if (pop) begin
                div_l    <= DIV;
                par_en_l <= PARITY_EN;
                par_bit  <= (^head) ^ PARITY_ODD;
                stop2_l  <= STOP2;
            end
        end
    end
endmodule
`default_nettype wire
